// File: rtl/drv_ad56x3_gen.sv
// drv_ad56x3_gen: dual sawtooth test-pattern generator for the AD56x3 DAC.
// Emits channel-tagged sample pairs on a registered valid/ready stream.
module drv_ad56x3_gen #(
    parameter int DAC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             genSel,
    input  logic [15:0]      ceDivider,
    input  logic [15:0]      incrRate0,
    input  logic [15:0]      incrRate1,
    output logic [DAC_W-1:0] outData,
    output logic             outCh,
    output logic             outValid,
    input  logic             outReady,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SEND0,
        SEND1
    } state_t;

    state_t state, state_n;

    logic [15:0] cnt;
    logic [15:0] acc0, acc1;
    logic [15:0] snap0, snap1;
    logic [15:0] per_m1;
    logic        tick;
    logic        hs;
    logic        accept;

    logic [DAC_W-1:0] data_n;
    logic             valid_n;
    logic             ch_n;

    // A divider of 0 behaves like 1: one tick per cycle.
    assign per_m1 = (ceDivider == 16'd0) ? 16'd0 : ceDivider - 16'd1;
    assign tick   = genSel && (cnt >= per_m1);
    assign hs     = outValid && outReady;
    assign accept = tick && ((state == IDLE) || ((state == SEND1) && hs));

    // Sample-rate divider and free-running ramp accumulators.
    always_ff @(posedge clk) begin
        if (reset || !genSel) begin
            cnt  <= 16'd0;
            acc0 <= 16'd0;
            acc1 <= 16'd0;
        end else if (tick) begin
            cnt  <= 16'd0;
            acc0 <= acc0 + incrRate0;
            acc1 <= acc1 + incrRate1;
        end else begin
            cnt  <= cnt + 16'd1;
        end
    end

    // Capture the ramp pair only when the stream can take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap0 <= 16'd0;
            snap1 <= 16'd0;
        end else if (accept) begin
            snap0 <= acc0;
            snap1 <= acc1;
        end
    end

    // Next state and the registered output values that go with it.
    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        ch_n    = 1'b0;
        data_n  = '0;
        unique case (state)
            IDLE: begin
                if (accept) state_n = SEND0;
            end
            SEND0: begin
                if (hs) state_n = SEND1;
            end
            SEND1: begin
                if (accept)  state_n = SEND0;
                else if (hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        unique case (state_n)
            SEND0: begin
                valid_n = 1'b1;
                ch_n    = 1'b0;
                data_n  = accept ? acc0[15 -: DAC_W]
                                 : snap0[15 -: DAC_W];
            end
            SEND1: begin
                valid_n = 1'b1;
                ch_n    = 1'b1;
                data_n  = snap1[15 -: DAC_W];
            end
            default: begin
                valid_n = 1'b0;
                ch_n    = 1'b0;
                data_n  = '0;
            end
        endcase
    end

    // State and output registers; a dropped tick pulses overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            outValid <= 1'b0;
            outCh    <= 1'b0;
            outData  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            outValid <= valid_n;
            outCh    <= ch_n;
            outData  <= data_n;
            overrun  <= tick && !accept;
        end
    end

endmodule

// File: tb/tb_drv_ad56x3_gen.sv
// tb_drv_ad56x3_gen: randomized bench for drv_ad56x3_gen.
// A transaction-level reference predicts every output cycle.
module tb_drv_ad56x3_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         genSel = 1'b0;
    logic [15:0]  ceDivider = 16'd125;
    logic [15:0]  incrRate0 = 16'd1;
    logic [15:0]  incrRate1 = 16'hFFFF;
    logic [W-1:0] outData;
    logic         outCh;
    logic         outValid;
    logic         outReady = 1'b1;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    int n = 0;
    int en = 0;
    int pend = 0;
    logic [15:0] e0 = 16'd0;
    logic [15:0] e1 = 16'd0;
    int ovr_cnt = 0;

    drv_ad56x3_gen #(.DAC_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .genSel    (genSel),
        .ceDivider (ceDivider),
        .incrRate0 (incrRate0),
        .incrRate1 (incrRate1),
        .outData   (outData),
        .outCh     (outCh),
        .outValid  (outValid),
        .outReady  (outReady),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s edge %0d got %0h want %0h",
                     tag, n, obs, exp);
        end
    endtask

    // Reference: ticks fall every P edges after enable; a pair in
    // flight is counted down by handshakes, and a tick is taken only
    // when no word would still be pending after this edge.
    always @(posedge clk) begin
        int  p;
        bit  tick;
        bit  ovr;
        longint k;
        #1;
        n++;
        p = (ceDivider == 16'd0) ? 1 : int'(ceDivider);
        ovr = 1'b0;
        tick = 1'b0;
        if (reset) begin
            pend = 0;
            en = n;
        end else begin
            if (pend > 0 && outReady) pend--;
            if (!genSel) en = n;
            else tick = ((n - en) % p) == 0;
            if (tick) begin
                if (pend == 0) begin
                    k = longint'((n - en) / p) - 1;
                    e0 = 16'(k * longint'(incrRate0));
                    e1 = 16'(k * longint'(incrRate1));
                    pend = 2;
                end else begin
                    ovr = 1'b1;
                    ovr_cnt++;
                end
            end
        end
        check("valid", 32'(outValid), 32'(pend > 0));
        check("overrun", 32'(overrun), 32'(ovr));
        if (pend > 0 && outValid) begin
            check("ch", 32'(outCh), 32'(pend == 1));
            if (pend == 2) check("data0", 32'(outData), 32'(e0[15 -: W]));
            else           check("data1", 32'(outData), 32'(e1[15 -: W]));
        end
    end

    // mode 0: ready low, 1: ready high, 2: random ready
    task automatic cyc(input int cnt, input int mode);
        repeat (cnt) begin
            @(posedge clk);
            #2;
            case (mode)
                0: outReady = 1'b0;
                1: outReady = 1'b1;
                default: outReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic run(input logic [15:0] div,
                       input logic [15:0] i0,
                       input logic [15:0] i1,
                       input int cnt, input int mode);
        genSel = 1'b0;
        cyc(3, 1);
        ceDivider = div;
        incrRate0 = i0;
        incrRate1 = i1;
        genSel = 1'b1;
        cyc(cnt, mode);
    endtask

    initial begin
        int ov0;
        cyc(3, 1);
        reset = 1'b0;
        cyc(2, 1);

        // Default ramps: +1 and -1 at P=125.
        ov0 = ovr_cnt;
        run(16'd125, 16'd1, 16'hFFFF, 125 * 6, 1);
        check("no_overrun_default", 32'(ovr_cnt - ov0), 32'd0);

        // Quarter-scale steps wrap every four samples.
        run(16'd4, 16'h4000, 16'(16'hC000), 40, 1);

        // Stall ready for 10 cycles right after the first valid.
        ov0 = ovr_cnt;
        genSel = 1'b0;
        cyc(3, 1);
        ceDivider = 16'd4;
        incrRate0 = 16'd1;
        incrRate1 = 16'hFFFF;
        genSel = 1'b1;
        cyc(3, 1);
        cyc(10, 0);
        cyc(30, 1);
        check("stall_overruns", 32'(ovr_cnt - ov0), 32'd2);

        // Minimum periods.
        ov0 = ovr_cnt;
        run(16'd2, 16'd7, 16'd3, 40, 1);
        check("p2_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
        ov0 = ovr_cnt;
        run(16'd0, 16'd5, 16'hFFF0, 30, 1);
        check("p0_overruns", 32'(ovr_cnt - ov0 > 10), 32'd1);
        run(16'd1, 16'h0101, 16'h8000, 30, 1);

        // Randomized divider, steps and backpressure.
        for (int r = 0; r < 12; r++) begin
            run(16'($urandom_range(0, 9)), 16'($urandom),
                16'($urandom), 150, 2);
        end

        // Disable while SEND0 is stalled.
        genSel = 1'b0;
        cyc(3, 1);
        ceDivider = 16'd5;
        incrRate0 = 16'd9;
        incrRate1 = 16'd2;
        genSel = 1'b1;
        cyc(4, 1);
        cyc(3, 0);
        genSel = 1'b0;
        cyc(3, 0);
        cyc(15, 1);
        genSel = 1'b1;
        cyc(30, 1);

        // Reset during a stalled SEND1.
        genSel = 1'b0;
        cyc(3, 1);
        ceDivider = 16'd6;
        incrRate0 = 16'd3;
        incrRate1 = 16'd4;
        genSel = 1'b1;
        cyc(6, 1);
        cyc(3, 0);
        reset = 1'b1;
        cyc(1, 0);
        reset = 1'b0;
        cyc(40, 1);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
